// File: rtl/cpu_state_sequencer_pkg.sv
// Shared state encodings and strobe payload for the instruction-cycle sequencer.
package cpu_state_sequencer_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_REQ  = 3'd1,
        ST_FETCH_RECV = 3'd2,
        ST_DECODE     = 3'd3,
        ST_SETUP      = 3'd4,
        ST_EXECUTE    = 3'd5,
        ST_WRITEBACK  = 3'd6
    } state_e;

    typedef struct packed {
        logic fetch_req;
        logic fetch_recv;
        logic decode;
        logic setup;
        logic execute;
        logic writeback;
    } strobes_t;

    // One-hot strobe pattern for a state; IDLE and unused codes give all zeros.
    function automatic strobes_t decode_strobes(input state_e st);
        strobes_t s;
        s = '0;
        case (st)
            ST_FETCH_REQ:  s.fetch_req  = 1'b1;
            ST_FETCH_RECV: s.fetch_recv = 1'b1;
            ST_DECODE:     s.decode     = 1'b1;
            ST_SETUP:      s.setup      = 1'b1;
            ST_EXECUTE:    s.execute    = 1'b1;
            ST_WRITEBACK:  s.writeback  = 1'b1;
            default:       s            = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cpu_state_sequencer_wrap_counter.sv
// Free-running wrap-around counter with enable and synchronous clear (clear wins).
module wrap_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cpu_state_sequencer.sv
// Instruction-cycle sequencer: fetch handshake, multi-cycle execute wait,
// registered one-hot state strobes, cycle/retired counters and fetch timeout.
module cpu_state_sequencer
    import cpu_state_sequencer_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH   = 32,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   imem_ready,
    input  logic                   exec_done,
    input  logic                   timeout_clear,
    output logic                   fetch_RequestState,
    output logic                   fetch_ReceiveState,
    output logic                   decodeState,
    output logic                   setupState,
    output logic                   executeState,
    output logic                   writebackState,
    output logic                   imem_req,
    output logic                   idle,
    output logic                   fetch_timeout,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    localparam int unsigned WAIT_W = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;

    state_e      state_q, state_d;
    strobes_t    strobes_q, strobes_d;
    logic        idle_q, idle_d;
    logic        fetch_timeout_q, fetch_timeout_d;
    logic [WAIT_W-1:0] wait_count;
    logic        go;
    logic        timeout_hit;
    logic        wait_en;

    // imem_ready on the limit cycle beats the timeout
    assign timeout_hit = (FETCH_TIMEOUT != 0) && (state_q == ST_FETCH_RECV) && !imem_ready
                         && (wait_count == WAIT_W'(FETCH_TIMEOUT));
    assign wait_en     = (state_q == ST_FETCH_RECV) && !imem_ready && !timeout_hit;
    // A same-cycle clear releases the sticky timeout for the issue decision too
    assign go          = run && (!fetch_timeout_q || timeout_clear);

    always_comb begin
        state_d         = state_q;
        fetch_timeout_d = fetch_timeout_q;
        case (state_q)
            ST_IDLE:       if (go) state_d = ST_FETCH_REQ;
            ST_FETCH_REQ:  state_d = ST_FETCH_RECV;
            ST_FETCH_RECV: begin
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE:     state_d = ST_SETUP;
            ST_SETUP:      state_d = ST_EXECUTE;
            ST_EXECUTE:    if (exec_done) state_d = ST_WRITEBACK;
            ST_WRITEBACK:  state_d = go ? ST_FETCH_REQ : ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase

        if (timeout_clear) begin
            fetch_timeout_d = 1'b0;
        end else if (timeout_hit) begin
            fetch_timeout_d = 1'b1;
        end

        strobes_d = decode_strobes(state_d);
        idle_d    = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            strobes_q       <= '0;
            idle_q          <= 1'b1;
            fetch_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            strobes_q       <= strobes_d;
            idle_q          <= idle_d;
            fetch_timeout_q <= fetch_timeout_d;
        end
    end

    wrap_counter #(.WIDTH(COUNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (state_q != ST_IDLE),
        .clr   (1'b0),
        .count (cycle_count)
    );

    wrap_counter #(.WIDTH(COUNT_WIDTH)) u_retired_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (state_q == ST_WRITEBACK),
        .clr   (1'b0),
        .count (retired_count)
    );

    wrap_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (wait_en),
        .clr   (!wait_en),
        .count (wait_count)
    );

    assign fetch_RequestState = strobes_q.fetch_req;
    assign fetch_ReceiveState = strobes_q.fetch_recv;
    assign decodeState        = strobes_q.decode;
    assign setupState         = strobes_q.setup;
    assign executeState       = strobes_q.execute;
    assign writebackState     = strobes_q.writeback;
    assign imem_req           = strobes_q.fetch_req;
    assign idle               = idle_q;
    assign fetch_timeout      = fetch_timeout_q;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Scoreboard bench: directed per-cycle vectors push expected outputs, a monitor pops and compares.
module tb_cpu_state_sequencer;
    import cpu_state_sequencer_pkg::*;

    localparam int unsigned CW = 4;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run = 1'b0;
    logic imem_ready = 1'b0;
    logic exec_done = 1'b0;
    logic timeout_clear = 1'b0;
    logic fetch_RequestState, fetch_ReceiveState, decodeState;
    logic setupState, executeState, writebackState;
    logic imem_req, idle, fetch_timeout;
    logic [CW-1:0] cycle_count, retired_count;

    cpu_state_sequencer #(.COUNT_WIDTH(CW), .FETCH_TIMEOUT(TO)) dut (
        .clk                (clk),
        .reset              (reset),
        .run                (run),
        .imem_ready         (imem_ready),
        .exec_done          (exec_done),
        .timeout_clear      (timeout_clear),
        .fetch_RequestState (fetch_RequestState),
        .fetch_ReceiveState (fetch_ReceiveState),
        .decodeState        (decodeState),
        .setupState         (setupState),
        .executeState       (executeState),
        .writebackState     (writebackState),
        .imem_req           (imem_req),
        .idle               (idle),
        .fetch_timeout      (fetch_timeout),
        .cycle_count        (cycle_count),
        .retired_count      (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        state_e        st;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ret;
        logic          to;
    } exp_t;

    exp_t sb_q[$];
    int errors = 0;
    int checks = 0;

    // Hand-sequenced expectation: previous expected state drives counter bookkeeping
    state_e        m_st  = ST_IDLE;
    logic [CW-1:0] m_cyc = '0;
    logic [CW-1:0] m_ret = '0;

    function automatic logic [5:0] exp_strobes(input state_e s);
        case (s)
            ST_FETCH_REQ:  return 6'b100000;
            ST_FETCH_RECV: return 6'b010000;
            ST_DECODE:     return 6'b001000;
            ST_SETUP:      return 6'b000100;
            ST_EXECUTE:    return 6'b000010;
            ST_WRITEBACK:  return 6'b000001;
            default:       return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] act_strobes();
        return {fetch_RequestState, fetch_ReceiveState, decodeState,
                setupState, executeState, writebackState};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs for the edge that lands in state nxt with fetch_timeout = to
    task automatic step(input logic r, input logic rdy, input logic dn, input logic clr,
                        input state_e nxt, input logic to);
        exp_t e;
        @(negedge clk);
        run = r;
        imem_ready = rdy;
        exec_done = dn;
        timeout_clear = clr;
        if (m_st != ST_IDLE) m_cyc = m_cyc + 1'b1;
        if (m_st == ST_WRITEBACK) m_ret = m_ret + 1'b1;
        m_st = nxt;
        e.st = nxt;
        e.cyc = m_cyc;
        e.ret = m_ret;
        e.to = to;
        sb_q.push_back(e);
    endtask

    // Best-case instruction: immediate ready, single-cycle execute
    task automatic instr();
        step(1, 1, 1, 0, ST_FETCH_REQ, 0);
        step(1, 1, 1, 0, ST_FETCH_RECV, 0);
        step(1, 1, 1, 0, ST_DECODE, 0);
        step(1, 1, 1, 0, ST_SETUP, 0);
        step(1, 1, 1, 0, ST_EXECUTE, 0);
        step(1, 1, 1, 0, ST_WRITEBACK, 0);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_strobes"}, 32'(act_strobes()), 32'h0);
        check({tag, "_imem_req"}, 32'(imem_req), 32'h0);
        check({tag, "_idle"}, 32'(idle), 32'h1);
        check({tag, "_fetch_timeout"}, 32'(fetch_timeout), 32'h0);
        check({tag, "_cycle_count"}, 32'(cycle_count), 32'h0);
        check({tag, "_retired_count"}, 32'(retired_count), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        run = 1'b0;
        imem_ready = 1'b0;
        exec_done = 1'b0;
        timeout_clear = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_st = ST_IDLE;
        m_cyc = '0;
        m_ret = '0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("strobes", 32'(act_strobes()), 32'(exp_strobes(e.st)));
                check("imem_req", 32'(imem_req), 32'(e.st == ST_FETCH_REQ));
                check("idle", 32'(idle), 32'(e.st == ST_IDLE));
                check("fetch_timeout", 32'(fetch_timeout), 32'(e.to));
                check("cycle_count", 32'(cycle_count), 32'(e.cyc));
                check("retired_count", 32'(retired_count), 32'(e.ret));
            end
        end
    end

    initial begin : stimulus
        logic [5:0] s;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back best case, then stop; inputs in IDLE are ignored
        repeat (3) instr();
        step(0, 0, 0, 0, ST_IDLE, 0);
        step(0, 1, 1, 0, ST_IDLE, 0);
        drain();
        check("retired_after_18", 32'(retired_count), 32'd3);

        // Fetch wait of 4 cycles; exec_done during fetch is ignored
        step(1, 0, 1, 0, ST_FETCH_REQ, 0);
        step(1, 0, 1, 0, ST_FETCH_RECV, 0);
        repeat (4) step(1, 0, 1, 0, ST_FETCH_RECV, 0);
        step(1, 1, 0, 0, ST_DECODE, 0);
        step(0, 0, 0, 0, ST_SETUP, 0);
        step(0, 0, 0, 0, ST_EXECUTE, 0);
        step(0, 0, 1, 0, ST_WRITEBACK, 0);
        step(0, 0, 0, 0, ST_IDLE, 0);
        drain();

        // Execute held 3 extra cycles; imem_ready during execute is ignored
        do_reset();
        step(1, 1, 0, 0, ST_FETCH_REQ, 0);
        step(1, 1, 0, 0, ST_FETCH_RECV, 0);
        step(1, 1, 0, 0, ST_DECODE, 0);
        step(1, 1, 0, 0, ST_SETUP, 0);
        step(1, 1, 0, 0, ST_EXECUTE, 0);
        repeat (3) step(1, 1, 0, 0, ST_EXECUTE, 0);
        step(0, 0, 1, 0, ST_WRITEBACK, 0);
        step(0, 0, 0, 0, ST_IDLE, 0);
        drain();
        check("cycles_at_wb_exit", 32'(cycle_count), 32'd9);

        // Timeout abort, sticky flag blocks run, clear restarts
        step(1, 0, 0, 0, ST_FETCH_REQ, 0);
        step(1, 0, 0, 0, ST_FETCH_RECV, 0);
        repeat (TO) step(1, 0, 0, 0, ST_FETCH_RECV, 0);
        step(1, 0, 0, 0, ST_IDLE, 1);
        repeat (3) step(1, 0, 0, 0, ST_IDLE, 1);
        step(1, 0, 0, 1, ST_FETCH_REQ, 0);
        step(1, 0, 0, 0, ST_FETCH_RECV, 0);
        step(1, 1, 0, 0, ST_DECODE, 0);
        step(1, 0, 0, 0, ST_SETUP, 0);
        step(1, 0, 0, 0, ST_EXECUTE, 0);
        step(1, 0, 1, 0, ST_WRITEBACK, 0);
        // Ready on the limit cycle wins over timeout
        step(1, 0, 0, 0, ST_FETCH_REQ, 0);
        step(1, 0, 0, 0, ST_FETCH_RECV, 0);
        repeat (TO) step(1, 0, 0, 0, ST_FETCH_RECV, 0);
        step(1, 1, 0, 0, ST_DECODE, 0);
        step(1, 0, 0, 0, ST_SETUP, 0);
        step(1, 0, 0, 0, ST_EXECUTE, 0);
        step(1, 0, 1, 0, ST_WRITEBACK, 0);
        // Clear on the timeout cycle beats the set
        step(1, 0, 0, 0, ST_FETCH_REQ, 0);
        step(1, 0, 0, 0, ST_FETCH_RECV, 0);
        repeat (TO) step(1, 0, 0, 0, ST_FETCH_RECV, 0);
        step(1, 0, 0, 1, ST_IDLE, 0);
        step(1, 0, 0, 0, ST_FETCH_REQ, 0);
        step(1, 0, 0, 0, ST_FETCH_RECV, 0);
        step(1, 1, 0, 0, ST_DECODE, 0);
        step(1, 0, 0, 0, ST_SETUP, 0);
        step(1, 0, 0, 0, ST_EXECUTE, 0);
        step(1, 0, 1, 0, ST_WRITEBACK, 0);
        step(0, 0, 0, 0, ST_IDLE, 0);
        drain();

        // run dropped during DECODE: instruction completes
        step(1, 0, 0, 0, ST_FETCH_REQ, 0);
        step(1, 0, 0, 0, ST_FETCH_RECV, 0);
        step(1, 1, 0, 0, ST_DECODE, 0);
        step(0, 0, 0, 0, ST_SETUP, 0);
        step(0, 0, 0, 0, ST_EXECUTE, 0);
        step(0, 0, 1, 0, ST_WRITEBACK, 0);
        step(0, 0, 0, 0, ST_IDLE, 0);
        step(0, 0, 0, 0, ST_IDLE, 0);
        drain();

        // Async reset mid-EXECUTE, checked with no clock edge
        step(1, 0, 0, 0, ST_FETCH_REQ, 0);
        step(1, 0, 0, 0, ST_FETCH_RECV, 0);
        step(1, 1, 0, 0, ST_DECODE, 0);
        step(1, 0, 0, 0, ST_SETUP, 0);
        step(1, 0, 0, 0, ST_EXECUTE, 0);
        step(1, 0, 0, 0, ST_EXECUTE, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        m_st = ST_IDLE;
        m_cyc = '0;
        m_ret = '0;

        // 17 back-to-back instructions wrap both 4-bit counters
        repeat (17) instr();
        step(0, 0, 0, 0, ST_IDLE, 0);
        drain();
        check("retired_wrap", 32'(retired_count), 32'd1);
        check("cycles_wrap", 32'(cycle_count), 32'd6);

        // Random inputs: strobes one-hot or zero, side outputs consistent
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            run = 1'($urandom_range(0, 3) != 0);
            imem_ready = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            timeout_clear = 1'($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
            s = act_strobes();
            checks++;
            if (!$onehot0(s)) begin
                errors++;
                $display("FAIL rand_onehot: got %b expected one-hot or zero", s);
            end
            check("rand_imem_req", 32'(imem_req), 32'(s[5]));
            check("rand_idle", 32'(idle), 32'(s == 6'b0));
        end

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL final_queue: %0d expectations left unchecked", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
